pong_renderer: RTL and testbench
================================

PONG_RENDERER -- requirements
Module: pong_renderer

Interface
REQ-001 Parameter X_POS_W, 10, horizontal coordinate width.
REQ-002 Parameter Y_POS_W, 10, vertical coordinate width.
REQ-003 Parameter SCREEN_H_RES, 640, visible pixels per line.
REQ-004 Parameter SCREEN_V_RES, 480, visible lines per frame.
REQ-005 Parameter PADDLE_WIDTH, 8, paddle width in pixels.
REQ-006 Parameter PADDLE_HEIGHT, 64, paddle height in pixels.
REQ-007 Parameter BALL_SIDE, 8, ball edge length in pixels.
REQ-008 Parameter SCREEN_BORDER, 4, thickness of the top and bottom border bands in pixels.
REQ-009 Parameters COL_BG 12'h000, COL_BORDER 12'hFFF, COL_NET 12'h888, COL_PLAYER 12'h0F0, COL_ENEMY 12'hF00, COL_BALL 12'hFF0; RGB444 colours.
REQ-010 clk_i  input  1  pixel clock; single clock domain; rising edge.
REQ-011 rst_i  input  1  reset; synchronous, active-high.
REQ-012 pix_x_i / pix_y_i  input  X_POS_W / Y_POS_W  current raster position from VGA timing.
REQ-013 visible_i  input  1  high while the raster is inside the active area.
REQ-014 player_x_i, enemy_x_i, ball_x_i  input  X_POS_W  sprite left edges.
REQ-015 player_y_i, enemy_y_i, ball_y_i  input  Y_POS_W  sprite top edges.
REQ-016 new_frame_o  output  1  one-cycle strobe to game logic at the start of vertical blanking.
REQ-017 rgb_o  output  12  pixel colour {R[3:0],G[3:0],B[3:0]}.
REQ-018 visible_o  output  1  visible_i delayed to align with rgb_o.

Function
REQ-019 Shadow registers SHALL capture all six position inputs on the cycle where pix_x_i==0 and pix_y_i==0; positions SHALL stay constant for the entire drawn frame.
REQ-020 Flag shadow_valid SHALL be 0 after reset and set by the first shadow capture; while 0, paddles and ball SHALL NOT be drawn.
REQ-021 new_frame_o SHALL be 1 for exactly one cycle when pix_x_i==0 and pix_y_i==SCREEN_V_RES, and 0 otherwise, including when that raster position is held for several cycles (edge-detect the match).
REQ-022 Pipeline: stage 1 registers pix_x, pix_y, visible; stage 2 registers the hit flags; stage 3 registers rgb_o and visible_o; total latency is exactly 3 cycles.
REQ-023 Sprite hit: x >= left AND x < left+W AND y >= top AND y < top+H, with the right and bottom sums computed 1 bit wider than the coordinate so that they cannot wrap.
REQ-024 The player and enemy paddles SHALL use PADDLE_WIDTH x PADDLE_HEIGHT; the ball SHALL use BALL_SIDE x BALL_SIDE.
REQ-025 Net hit: x in {SCREEN_H_RES/2-1, SCREEN_H_RES/2} AND y[3]==0 (dashed in 8-line segments).
REQ-026 Border hit: y < SCREEN_BORDER OR y >= SCREEN_V_RES-SCREEN_BORDER.
REQ-027 Colour priority: ball > player > enemy > net > border > background.
REQ-028 When the delayed visible is 0, rgb_o SHALL be 12'h000 regardless of hits.
REQ-029 Sprites partly off-screen SHALL be clipped naturally; no error state exists.

Reset
REQ-030 While rst_i is high, on each clock: rgb_o=0, visible_o=0, new_frame_o=0, all pipeline stages cleared, shadow_valid=0, shadow positions=0.
REQ-031 A reset asserted mid-frame SHALL blank output until the first valid pixel that enters the pipeline after reset deasserts, and SHALL suppress sprites until the next (0,0) capture.

Verification
REQ-032 Reset, run one frame with ball_x/y=100/50 -> no COL_BALL pixel before the first (0,0); rgb_o==0 throughout reset.
REQ-033 After capture with ball_x/y=100/50, present x=100,y=50 visible -> rgb_o=12'hFF0 exactly 3 cycles later; x=108,y=50 -> background or net, never ball.
REQ-034 Ball overlapping the player (player 600/200, ball 604/210), pixel 604/210 -> COL_BALL; pixel 600/200 -> COL_PLAYER.
REQ-035 Change ball_y mid-frame from 50 to 300 -> drawing still uses 50 until the next (0,0), then 300.
REQ-036 Hold pix_x=0, pix_y=480 for 5 cycles -> new_frame_o high exactly one cycle.
REQ-037 Pixel 319/0 with visible_i=0 -> rgb_o=0; with visible_i=1 -> COL_NET (net outranks border); pixel 10/477 -> COL_BORDER.

Source files
------------

// File: rtl/pong_renderer.sv
// Pong frame renderer: turns the raster position into an RGB444 pixel through a
// 3-stage pipeline. Sprite positions are latched once per frame at pixel (0,0).
module pong_renderer #(
  parameter int          X_POS_W       = 10,
  parameter int          Y_POS_W       = 10,
  parameter int          SCREEN_H_RES  = 640,
  parameter int          SCREEN_V_RES  = 480,
  parameter int          PADDLE_WIDTH  = 8,
  parameter int          PADDLE_HEIGHT = 64,
  parameter int          BALL_SIDE     = 8,
  parameter int          SCREEN_BORDER = 4,
  parameter logic [11:0] COL_BG        = 12'h000,
  parameter logic [11:0] COL_BORDER    = 12'hFFF,
  parameter logic [11:0] COL_NET       = 12'h888,
  parameter logic [11:0] COL_PLAYER    = 12'h0F0,
  parameter logic [11:0] COL_ENEMY     = 12'hF00,
  parameter logic [11:0] COL_BALL      = 12'hFF0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [X_POS_W-1:0] pix_x_i,
  input  logic [Y_POS_W-1:0] pix_y_i,
  input  logic               visible_i,
  input  logic [X_POS_W-1:0] player_x_i,
  input  logic [Y_POS_W-1:0] player_y_i,
  input  logic [X_POS_W-1:0] enemy_x_i,
  input  logic [Y_POS_W-1:0] enemy_y_i,
  input  logic [X_POS_W-1:0] ball_x_i,
  input  logic [Y_POS_W-1:0] ball_y_i,
  output logic               new_frame_o,
  output logic [11:0]        rgb_o,
  output logic               visible_o
);

  localparam int N_SPR      = 3;
  localparam int SPR_PLAYER = 0;
  localparam int SPR_ENEMY  = 1;
  localparam int SPR_BALL   = 2;

  localparam logic [X_POS_W-1:0] NET_X0     = X_POS_W'(SCREEN_H_RES / 2 - 1);
  localparam logic [X_POS_W-1:0] NET_X1     = X_POS_W'(SCREEN_H_RES / 2);
  localparam logic [Y_POS_W-1:0] BORDER_TOP = Y_POS_W'(SCREEN_BORDER);
  localparam logic [Y_POS_W-1:0] BORDER_BOT = Y_POS_W'(SCREEN_V_RES - SCREEN_BORDER);
  localparam logic [Y_POS_W-1:0] VBLANK_Y   = Y_POS_W'(SCREEN_V_RES);

  logic frame_start;
  logic vblank_match;

  assign frame_start  = (pix_x_i == '0) && (pix_y_i == '0);
  assign vblank_match = (pix_x_i == '0) && (pix_y_i == VBLANK_Y);

  // Sprite inputs gathered into arrays so the per-sprite logic can be generated.
  logic [X_POS_W-1:0] pos_x_in [N_SPR];
  logic [Y_POS_W-1:0] pos_y_in [N_SPR];

  assign pos_x_in[SPR_PLAYER] = player_x_i;
  assign pos_y_in[SPR_PLAYER] = player_y_i;
  assign pos_x_in[SPR_ENEMY]  = enemy_x_i;
  assign pos_y_in[SPR_ENEMY]  = enemy_y_i;
  assign pos_x_in[SPR_BALL]   = ball_x_i;
  assign pos_y_in[SPR_BALL]   = ball_y_i;

  // Frame-start strobe for game logic, edge-detected so a held position fires once.
  logic vblank_match_prev_reg;
  logic new_frame_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vblank_match_prev_reg <= 1'b0;
      new_frame_reg         <= 1'b0;
    end else begin
      vblank_match_prev_reg <= vblank_match;
      new_frame_reg         <= vblank_match && !vblank_match_prev_reg;
    end
  end

  assign new_frame_o = new_frame_reg;

  logic shadow_valid_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_valid_reg <= 1'b0;
    end else if (frame_start) begin
      shadow_valid_reg <= 1'b1;
    end
  end

  // Stage 1: raster position and visibility.
  logic [X_POS_W-1:0] s1_x_reg;
  logic [Y_POS_W-1:0] s1_y_reg;
  logic               s1_vis_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_x_reg   <= '0;
      s1_y_reg   <= '0;
      s1_vis_reg <= 1'b0;
    end else begin
      s1_x_reg   <= pix_x_i;
      s1_y_reg   <= pix_y_i;
      s1_vis_reg <= visible_i;
    end
  end

  logic [N_SPR-1:0] spr_hit;

  // Per-sprite shadow position and bounding-box test; right/bottom edges carry
  // an extra bit so sprites near the coordinate limit clip instead of wrapping.
  for (genvar gi = 0; gi < N_SPR; gi++) begin : g_sprite
    localparam int SPR_W = (gi == SPR_BALL) ? BALL_SIDE : PADDLE_WIDTH;
    localparam int SPR_H = (gi == SPR_BALL) ? BALL_SIDE : PADDLE_HEIGHT;

    logic [X_POS_W-1:0] shadow_x_reg;
    logic [Y_POS_W-1:0] shadow_y_reg;
    logic [X_POS_W:0]   right_edge;
    logic [Y_POS_W:0]   bottom_edge;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        shadow_x_reg <= '0;
        shadow_y_reg <= '0;
      end else if (frame_start) begin
        shadow_x_reg <= pos_x_in[gi];
        shadow_y_reg <= pos_y_in[gi];
      end
    end

    assign right_edge  = {1'b0, shadow_x_reg} + (X_POS_W + 1)'(SPR_W);
    assign bottom_edge = {1'b0, shadow_y_reg} + (Y_POS_W + 1)'(SPR_H);

    assign spr_hit[gi] = shadow_valid_reg
                      && (s1_x_reg >= shadow_x_reg)
                      && ({1'b0, s1_x_reg} < right_edge)
                      && (s1_y_reg >= shadow_y_reg)
                      && ({1'b0, s1_y_reg} < bottom_edge);
  end

  logic net_hit;
  logic border_hit;

  assign net_hit    = ((s1_x_reg == NET_X0) || (s1_x_reg == NET_X1)) && !s1_y_reg[3];
  assign border_hit = (s1_y_reg < BORDER_TOP) || (s1_y_reg >= BORDER_BOT);

  // Stage 2: hit flags.
  logic [N_SPR-1:0] s2_spr_hit_reg;
  logic             s2_net_reg;
  logic             s2_border_reg;
  logic             s2_vis_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_spr_hit_reg <= '0;
      s2_net_reg     <= 1'b0;
      s2_border_reg  <= 1'b0;
      s2_vis_reg     <= 1'b0;
    end else begin
      s2_spr_hit_reg <= spr_hit;
      s2_net_reg     <= net_hit;
      s2_border_reg  <= border_hit;
      s2_vis_reg     <= s1_vis_reg;
    end
  end

  logic [11:0] rgb_next;

  always_comb begin
    rgb_next = COL_BG;
    if (!s2_vis_reg) begin
      rgb_next = 12'h000;
    end else if (s2_spr_hit_reg[SPR_BALL]) begin
      rgb_next = COL_BALL;
    end else if (s2_spr_hit_reg[SPR_PLAYER]) begin
      rgb_next = COL_PLAYER;
    end else if (s2_spr_hit_reg[SPR_ENEMY]) begin
      rgb_next = COL_ENEMY;
    end else if (s2_net_reg) begin
      rgb_next = COL_NET;
    end else if (s2_border_reg) begin
      rgb_next = COL_BORDER;
    end
  end

  // Stage 3: output colour and aligned visibility.
  logic [11:0] rgb_reg;
  logic        visible_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rgb_reg     <= 12'h000;
      visible_reg <= 1'b0;
    end else begin
      rgb_reg     <= rgb_next;
      visible_reg <= s2_vis_reg;
    end
  end

  assign rgb_o     = rgb_reg;
  assign visible_o = visible_reg;

endmodule

// File: tb/tb_pong_renderer.sv
// Directed bench for pong_renderer: stimulus pushes expected pixels into a
// scoreboard that a negedge monitor pops when each result falls due.
module tb_pong_renderer;

  localparam logic [11:0] BG     = 12'h000;
  localparam logic [11:0] BORDER = 12'hFFF;
  localparam logic [11:0] NET    = 12'h888;
  localparam logic [11:0] PLAYER = 12'h0F0;
  localparam logic [11:0] ENEMY  = 12'hF00;
  localparam logic [11:0] BALL   = 12'hFF0;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] pix_x, player_x, enemy_x, ball_x;
  logic [9:0] pix_y, player_y, enemy_y, ball_y;
  logic       vis_in;
  logic       new_frame, vis_out;
  logic [11:0] rgb;

  always #5 clk = ~clk;

  pong_renderer dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .pix_x_i     (pix_x),
    .pix_y_i     (pix_y),
    .visible_i   (vis_in),
    .player_x_i  (player_x),
    .player_y_i  (player_y),
    .enemy_x_i   (enemy_x),
    .enemy_y_i   (enemy_y),
    .ball_x_i    (ball_x),
    .ball_y_i    (ball_y),
    .new_frame_o (new_frame),
    .rgb_o       (rgb),
    .visible_o   (vis_out)
  );

  typedef struct {
    int          due;
    logic [11:0] rgb;
    logic        vis;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc       = 0;
  int   n_tests   = 0;
  int   n_fail    = 0;
  int   nf_count  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (new_frame) nf_count <= nf_count + 1;

  // Monitor: results are due 3 clocks after the inputs were applied.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      n_tests++;
      if (mon_e.due != cyc || rgb !== mon_e.rgb || vis_out !== mon_e.vis) begin
        n_fail++;
        $display("[TB] FAIL %s: rgb=%h vis=%b cyc=%0d, required rgb=%h vis=%b cyc=%0d",
                 mon_e.name, rgb, vis_out, cyc, mon_e.rgb, mon_e.vis, mon_e.due);
      end else begin
        $display("[TB] ok   %s: rgb=%h vis=%b", mon_e.name, rgb, vis_out);
      end
    end
  end

  task automatic pix(input int x, input int y, input logic v,
                     input logic [11:0] exp_rgb, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    pix_x  = 10'(x);
    pix_y  = 10'(y);
    vis_in = v;
    e.due  = cyc + 3;
    e.rgb  = exp_rgb;
    e.vis  = v;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      pix_x  = 10'd700;
      pix_y  = 10'd700;
      vis_in = 1'b0;
    end
  endtask

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end else begin
      $display("[TB] ok   %s: %0d", name, act);
    end
  endtask

  initial begin
    rst      = 1'b1;
    pix_x    = 10'd319;
    pix_y    = 10'd0;
    vis_in   = 1'b1;
    player_x = 10'd600; player_y = 10'd200;
    enemy_x  = 10'd20;  enemy_y  = 10'd100;
    ball_x   = 10'd100; ball_y   = 10'd50;

    // Output stays blank during reset even with a visible net pixel presented.
    repeat (2) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_rgb", int'(rgb), 0);
      check("reset_vis", int'(vis_out), 0);
      check("reset_nf", int'(new_frame), 0);
    end
    @(posedge clk);
    #1 rst = 1'b0;

    // Before any (0,0) capture, sprites must not be drawn.
    pix(100, 50, 1'b1, BG, "pre_cap_ball");
    pix(604, 210, 1'b1, BG, "pre_cap_player");
    pix(20, 100, 1'b1, BG, "pre_cap_enemy");
    pix(319, 0, 1'b1, NET, "net_over_border");
    pix(319, 0, 1'b0, BG, "invisible_net");
    pix(10, 477, 1'b1, BORDER, "border_bottom");

    // Frame A: capture ball 100/50.
    pix(0, 0, 1'b1, BORDER, "capture_a");
    pix(100, 50, 1'b1, BALL, "ball_tl");
    pix(107, 57, 1'b1, BALL, "ball_br");
    pix(108, 50, 1'b1, BG, "ball_right_out");
    pix(100, 58, 1'b1, BG, "ball_below_out");
    pix(99, 50, 1'b1, BG, "ball_left_out");
    pix(600, 200, 1'b1, PLAYER, "player_tl");
    pix(607, 263, 1'b1, PLAYER, "player_br");
    pix(608, 200, 1'b1, BG, "player_right_out");
    pix(600, 264, 1'b1, BG, "player_below_out");
    pix(20, 100, 1'b1, ENEMY, "enemy_tl");
    pix(27, 163, 1'b1, ENEMY, "enemy_br");
    pix(320, 8, 1'b1, BG, "net_gap");
    pix(320, 16, 1'b1, NET, "net_dash");
    pix(321, 16, 1'b1, BG, "net_right_out");
    pix(10, 3, 1'b1, BORDER, "border_top");
    pix(10, 4, 1'b1, BG, "border_top_out");
    pix(10, 476, 1'b1, BORDER, "border_bot_edge");
    pix(10, 475, 1'b1, BG, "border_bot_out");

    // Mid-frame position change is ignored until the next capture.
    ball_y = 10'd300;
    pix(100, 50, 1'b1, BALL, "ball_held_old");
    pix(100, 300, 1'b1, BG, "ball_not_new_yet");

    // Vertical-blank strobe with the position held for 5 cycles.
    idle(4);
    nf_count = 0;
    for (int i = 0; i < 5; i++) pix(0, 480, 1'b0, BG, "vblank_hold");
    idle(4);
    check("new_frame_pulses", nf_count, 1);

    // Frame B: ball now at 100/300.
    pix(0, 0, 1'b1, BORDER, "capture_b");
    pix(100, 300, 1'b1, BALL, "ball_new_pos");
    pix(100, 50, 1'b1, BG, "ball_old_gone");

    // Frame C: ball overlaps the player paddle.
    ball_x = 10'd604;
    ball_y = 10'd210;
    idle(2);
    pix(0, 0, 1'b1, BORDER, "capture_c");
    pix(604, 210, 1'b1, BALL, "ball_over_player");
    pix(600, 200, 1'b1, PLAYER, "player_beside_ball");
    pix(611, 217, 1'b1, BALL, "ball_br_overhang");
    pix(612, 210, 1'b1, BG, "ball_overhang_out");

    // Mid-frame reset: sprites suppressed until the next capture.
    idle(4);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    pix(604, 210, 1'b1, BG, "post_rst_no_ball");
    pix(319, 0, 1'b1, NET, "post_rst_net");
    pix(0, 0, 1'b1, BORDER, "capture_d");
    pix(604, 210, 1'b1, BALL, "post_rst_ball");

    idle(6);
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, required finish");
    $fatal(1);
  end

endmodule
